// File: rtl/fpga_robots_game_tick_pkg.sv
// Shared constants and helpers for the multi-channel timing-strobe generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fpga_robots_game_tick_pkg;

    // Register select values on cfg_sel.
    localparam logic CFG_SEL_STEP = 1'b0;
    localparam logic CFG_SEL_DIV  = 1'b1;

    // 115200 baud from a 65 MHz clock with a 19-bit accumulator:
    // 65e6 * 929 / 2^19 ~= 115.17 kHz.
    localparam logic [18:0] BAUD115200_STEP_65M = 19'd929;

    // Default step for the animation channel.
    localparam logic [19:0] ANIM_STEP = 20'd5;

    // Ceiling log2, usable in constant expressions (e.g. the channel-select width).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fpga_robots_game_tick_chan.sv
// One timing-strobe channel: NCO carry strobe, sub-tap strobe, divide-by-N strobe + toggle.
// Latency: all strobes registered, one cycle after the accumulate that produces them.
// Backpressure: none; strobes are fire-and-forget, en gates counting.
//
// Ports: clk/rst (async active-high), en_i global enable, clr_i phase clear,
//        cfg_we_i/cfg_sel_i/cfg_data_i local config write (already decoded for this channel),
//        tick_o/tick_sub_o/tick_div_o one-cycle strobes, tog_o toggles on each tick_div.
// DIV_W must not exceed ACC_W: the divisor is taken from the low bits of cfg_data_i.
module fpga_robots_game_tick_chan
    import fpga_robots_game_tick_pkg::*;
#(
    parameter int               ACC_W     = 19,
    parameter int               SUB_SH    = 3,
    parameter int               DIV_W     = 8,
    parameter logic [ACC_W-1:0] STEP_INIT = ACC_W'(929),
    parameter logic [DIV_W-1:0] DIV_INIT  = DIV_W'(6)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             cfg_we_i,
    input  logic             cfg_sel_i,
    input  logic [ACC_W-1:0] cfg_data_i,
    output logic             tick_o,
    output logic             tick_sub_o,
    output logic             tick_div_o,
    output logic             tog_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] step_q, step_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] divctr_q, divctr_d;
    logic             tick_q, tick_d;
    logic             tick_sub_q, tick_sub_d;
    logic             tick_div_q, tick_div_d;
    logic             tog_q, tog_d;

    logic [ACC_W:0]   nxt;
    logic             carry;
    logic             step_wr;
    logic             div_wr;

    // Extra top bit captures the accumulator carry.
    assign nxt   = {1'b0, acc_q} + {1'b0, step_q};
    assign carry = nxt[ACC_W];

    always_comb begin
        acc_d      = acc_q;
        step_d     = step_q;
        div_d      = div_q;
        divctr_d   = divctr_q;
        tog_d      = tog_q;
        tick_d     = 1'b0;
        tick_sub_d = 1'b0;
        tick_div_d = 1'b0;
        step_wr    = cfg_we_i && (cfg_sel_i == CFG_SEL_STEP);
        div_wr     = cfg_we_i && (cfg_sel_i == CFG_SEL_DIV);

        if (clr_i) begin
            // Clear beats config: any write landing on this cycle is dropped.
            acc_d    = '0;
            divctr_d = '0;
            tog_d    = 1'b0;
        end else begin
            // A new step only applies from the next accumulate; this cycle uses step_q.
            if (step_wr) begin
                step_d = cfg_data_i;
            end
            if (div_wr) begin
                div_d    = cfg_data_i[DIV_W-1:0];
                divctr_d = '0;
            end
            if (en_i) begin
                acc_d  = nxt[ACC_W-1:0];
                tick_d = carry;
                // A change of the tap bit marks one sub-period boundary.
                tick_sub_d = nxt[ACC_W-SUB_SH] ^ acc_q[ACC_W-SUB_SH];
                // Divisor write restarts the count and swallows this cycle's divide event.
                if (carry && !div_wr && (div_q != '0)) begin
                    if (divctr_q == div_q - DIV_W'(1)) begin
                        divctr_d   = '0;
                        tick_div_d = 1'b1;
                        tog_d      = ~tog_q;
                    end else begin
                        divctr_d = divctr_q + DIV_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            step_q     <= STEP_INIT;
            div_q      <= DIV_INIT;
            divctr_q   <= '0;
            tick_q     <= 1'b0;
            tick_sub_q <= 1'b0;
            tick_div_q <= 1'b0;
            tog_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            step_q     <= step_d;
            div_q      <= div_d;
            divctr_q   <= divctr_d;
            tick_q     <= tick_d;
            tick_sub_q <= tick_sub_d;
            tick_div_q <= tick_div_d;
            tog_q      <= tog_d;
        end
    end

    assign tick_o     = tick_q;
    assign tick_sub_o = tick_sub_q;
    assign tick_div_o = tick_div_q;
    assign tog_o      = tog_q;

endmodule

// File: rtl/fpga_robots_game_tick.sv
// Multi-channel timing-strobe generator (baud, PS/2, animation and other timed peripherals).
// Latency: one cycle from accumulate to strobe; no combinational input-to-output paths.
// Backpressure: none; config writes accepted every cycle, out-of-range cfg_ch ignored.
//
// Ports: clk/rst (async active-high), en global enable, clr[NCH] per-channel phase clear,
//        cfg_we/cfg_ch/cfg_sel/cfg_data config write port (sel 0 = step, 1 = divisor),
//        tick/tick_sub/tick_div[NCH] one-cycle strobes, tog[NCH] divide-stage toggles.
module fpga_robots_game_tick
    import fpga_robots_game_tick_pkg::*;
#(
    parameter int                     NCH       = 4,
    parameter int                     ACC_W     = 19,
    parameter int                     SUB_SH    = 3,
    parameter int                     DIV_W     = 8,
    parameter logic [NCH*ACC_W-1:0]   STEP_INIT = {4{19'd929}},
    parameter logic [NCH*DIV_W-1:0]   DIV_INIT  = {4{8'd6}},
    localparam int                    CH_W      = (NCH > 1) ? clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   clr,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic             cfg_sel,
    input  logic [ACC_W-1:0] cfg_data,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   tick_sub,
    output logic [NCH-1:0]   tick_div,
    output logic [NCH-1:0]   tog
);

    logic [NCH-1:0] ch_we;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        // Equality decode: a cfg_ch value at or above NCH matches no channel.
        assign ch_we[g] = cfg_we && (cfg_ch == CH_W'(g));

        fpga_robots_game_tick_chan #(
            .ACC_W     (ACC_W),
            .SUB_SH    (SUB_SH),
            .DIV_W     (DIV_W),
            .STEP_INIT (STEP_INIT[g*ACC_W +: ACC_W]),
            .DIV_INIT  (DIV_INIT[g*DIV_W +: DIV_W])
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en_i       (en),
            .clr_i      (clr[g]),
            .cfg_we_i   (ch_we[g]),
            .cfg_sel_i  (cfg_sel),
            .cfg_data_i (cfg_data),
            .tick_o     (tick[g]),
            .tick_sub_o (tick_sub[g]),
            .tick_div_o (tick_div[g]),
            .tog_o      (tog[g])
        );
    end

endmodule

// File: tb/tb_fpga_robots_game_tick.sv
module tb_fpga_robots_game_tick;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] clr = 4'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic       cfg_sel = 1'b0;
    logic [7:0] cfg_data = 8'd0;
    logic [3:0] tick, tick_sub, tick_div, tog;

    // Second instance with NCH=3: its cfg_ch is held at 3, which is out of range,
    // so every write the bench issues must be ignored by it.
    logic [2:0] clr2 = 3'b0;
    logic [1:0] cfg_ch2 = 2'd3;
    logic [2:0] tick2, tick_sub2, tick_div2, tog2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpga_robots_game_tick #(
        .NCH(4), .ACC_W(8), .SUB_SH(3), .DIV_W(8),
        .STEP_INIT({4{8'd64}}), .DIV_INIT({4{8'd6}})
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .tick(tick), .tick_sub(tick_sub), .tick_div(tick_div), .tog(tog)
    );

    fpga_robots_game_tick #(
        .NCH(3), .ACC_W(8), .SUB_SH(3), .DIV_W(8),
        .STEP_INIT({3{8'd64}}), .DIV_INIT({3{8'd6}})
    ) dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr2),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch2), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .tick(tick2), .tick_sub(tick_sub2), .tick_div(tick_div2), .tog(tog2)
    );

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = 1'b0; clr = 4'b0; cfg_we = 1'b0;
        tick_clk();
        rst = 1'b0;
    endtask

    // Single config write issued while en=0.
    task automatic cfg_write(input logic [1:0] ch, input logic sel, input logic [7:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = d;
        tick_clk();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        tick_clk();
        total++; if (tick !== 4'h0)     begin bad++; $display("FAIL reset_tick got=%h exp=0", tick); end
        total++; if (tick_sub !== 4'h0) begin bad++; $display("FAIL reset_sub got=%h exp=0", tick_sub); end
        total++; if (tick_div !== 4'h0) begin bad++; $display("FAIL reset_div got=%h exp=0", tick_div); end
        total++; if (tog !== 4'h0)      begin bad++; $display("FAIL reset_tog got=%h exp=0", tog); end
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick_clk();
            exp = (k % 4 == 0) ? 4'hF : 4'h0;
            total++; if (tick !== exp) begin bad++; $display("FAIL reset_seq_tick k=%0d got=%h exp=%h", k, tick, exp); end
        end
        total++; if (tick_div !== 4'hF) begin bad++; $display("FAIL first_div got=%h exp=f", tick_div); end
        total++; if (tog !== 4'hF)      begin bad++; $display("FAIL first_tog got=%h exp=f", tog); end
        // Async assertion mid-count clears outputs without a clock edge.
        rst = 1'b1;
        #1;
        total++; if (tick !== 4'h0)     begin bad++; $display("FAIL async_tick got=%h exp=0", tick); end
        total++; if (tick_div !== 4'h0) begin bad++; $display("FAIL async_div got=%h exp=0", tick_div); end
        total++; if (tog !== 4'h0)      begin bad++; $display("FAIL async_tog got=%h exp=0", tog); end
        en = 1'b0;
        tick_clk();
        rst = 1'b0;
    endtask

    task automatic test_subtap();
        logic et, es;
        apply_reset();
        cfg_write(2'd0, 1'b0, 8'd8);
        en = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick_clk();
            et = (k % 32 == 0);
            es = (k % 4 == 0);
            total++; if (tick[0] !== et)     begin bad++; $display("FAIL sub_tick k=%0d got=%b exp=%b", k, tick[0], et); end
            total++; if (tick_sub[0] !== es) begin bad++; $display("FAIL sub_strobe k=%0d got=%b exp=%b", k, tick_sub[0], es); end
        end
        en = 1'b0;
    endtask

    task automatic test_nco_no_drift();
        int win, all;
        win = 0; all = 0;
        apply_reset();
        cfg_write(2'd0, 1'b0, 8'd96);
        en = 1'b1;
        for (int k = 1; k <= 2048; k++) begin
            tick_clk();
            if (tick[0] === 1'b1) begin win++; all++; end
            if (k % 8 == 0) begin
                total++; if (win != 3) begin bad++; $display("FAIL nco_window k=%0d got=%0d exp=3", k, win); end
                win = 0;
            end
        end
        total++; if (all != 768) begin bad++; $display("FAIL nco_total got=%0d exp=768", all); end
        en = 1'b0;
    endtask

    task automatic test_divider();
        logic ediv, etog, et;
        etog = 1'b0;
        apply_reset();
        en = 1'b1;
        cfg_ch = 2'd0; cfg_sel = 1'b1; cfg_data = 8'd3;
        for (int k = 1; k <= 140; k++) begin
            cfg_we = (k == 120);
            tick_clk();
            et   = (k % 4 == 0);
            ediv = (k == 24 || k == 48 || k == 72 || k == 96 || k == 132);
            if (ediv) etog = ~etog;
            total++; if (tick[0] !== et)       begin bad++; $display("FAIL div_tick k=%0d got=%b exp=%b", k, tick[0], et); end
            total++; if (tick_div[0] !== ediv) begin bad++; $display("FAIL div_strobe k=%0d got=%b exp=%b", k, tick_div[0], ediv); end
            total++; if (tog[0] !== etog)      begin bad++; $display("FAIL div_tog k=%0d got=%b exp=%b", k, tog[0], etog); end
            if (k == 120) begin
                total++; if (tick_div[1] !== 1'b1) begin bad++; $display("FAIL div_other_ch got=%b exp=1", tick_div[1]); end
            end
        end
        cfg_we = 1'b0; en = 1'b0;
    endtask

    task automatic test_cfg();
        logic [3:0] et, ediv, etog;
        logic [2:0] et2, ediv2, etog2;
        apply_reset();
        en = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            cfg_we = (k == 2 || k == 3);
            cfg_ch   = (k == 2) ? 2'd2 : 2'd3;
            cfg_sel  = (k == 3);
            cfg_data = (k == 2) ? 8'd32 : 8'd0;
            tick_clk();
            et = (k % 4 == 0) ? 4'b1011 : 4'b0000;
            if (k >= 6 && (k - 6) % 8 == 0) et[2] = 1'b1;
            ediv = (k == 24 || k == 48) ? 4'b0011 : 4'b0000;
            if (k == 46) ediv[2] = 1'b1;
            etog = (k >= 24 && k < 48) ? 4'b0011 : 4'b0000;
            if (k >= 46) etog[2] = 1'b1;
            et2   = (k % 4 == 0) ? 3'b111 : 3'b000;
            ediv2 = (k == 24 || k == 48) ? 3'b111 : 3'b000;
            etog2 = (k >= 24 && k < 48) ? 3'b111 : 3'b000;
            total++; if (tick !== et)      begin bad++; $display("FAIL cfg_tick k=%0d got=%b exp=%b", k, tick, et); end
            total++; if (tick_div !== ediv) begin bad++; $display("FAIL cfg_div k=%0d got=%b exp=%b", k, tick_div, ediv); end
            total++; if (tog !== etog)     begin bad++; $display("FAIL cfg_tog k=%0d got=%b exp=%b", k, tog, etog); end
            total++; if (tick2 !== et2)    begin bad++; $display("FAIL oor_tick k=%0d got=%b exp=%b", k, tick2, et2); end
            total++; if (tick_div2 !== ediv2) begin bad++; $display("FAIL oor_div k=%0d got=%b exp=%b", k, tick_div2, ediv2); end
            total++; if (tog2 !== etog2)   begin bad++; $display("FAIL oor_tog k=%0d got=%b exp=%b", k, tog2, etog2); end
        end
        cfg_we = 1'b0; en = 1'b0;
    endtask

    task automatic test_clr_en();
        logic [3:0] et, ediv, etog;
        apply_reset();
        for (int k = 1; k <= 62; k++) begin
            en  = !(k >= 31 && k <= 40);
            clr = (k == 27) ? 4'b0010 : 4'b0000;
            tick_clk();
            if (k == 24) begin
                total++; if (tog !== 4'hF) begin bad++; $display("FAIL clr_pre_tog got=%b exp=1111", tog); end
            end
            if (k >= 27) begin
                et = 4'b0000;
                if (k == 28 || (k >= 42 && (k - 42) % 4 == 0)) et = et | 4'b1101;
                if (k >= 41 && (k - 41) % 4 == 0)              et = et | 4'b0010;
                ediv = (k == 58) ? 4'b1101 : ((k == 61) ? 4'b0010 : 4'b0000);
                etog = ((k < 58) ? 4'b1101 : 4'b0000) | ((k >= 61) ? 4'b0010 : 4'b0000);
                total++; if (tick !== et)       begin bad++; $display("FAIL clr_tick k=%0d got=%b exp=%b", k, tick, et); end
                total++; if (tick_sub !== 4'h0) begin bad++; $display("FAIL clr_sub k=%0d got=%b exp=0000", k, tick_sub); end
                total++; if (tick_div !== ediv) begin bad++; $display("FAIL clr_div k=%0d got=%b exp=%b", k, tick_div, ediv); end
                total++; if (tog !== etog)      begin bad++; $display("FAIL clr_tog k=%0d got=%b exp=%b", k, tog, etog); end
            end
        end
        clr = 4'b0; en = 1'b0;
    endtask

    task automatic test_max_step();
        logic [3:0] et, ediv;
        apply_reset();
        cfg_write(2'd0, 1'b0, 8'd255);
        cfg_write(2'd1, 1'b0, 8'd0);
        cfg_write(2'd2, 1'b1, 8'd1);
        en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick_clk();
            et = (k % 4 == 0) ? 4'b1100 : 4'b0000;
            et[0] = (k >= 2);
            ediv = (k % 4 == 0) ? 4'b0100 : 4'b0000;
            ediv[0] = (k == 7 || k == 13 || k == 19);
            total++; if (tick !== et)       begin bad++; $display("FAIL max_tick k=%0d got=%b exp=%b", k, tick, et); end
            total++; if (tick_div !== ediv) begin bad++; $display("FAIL max_div k=%0d got=%b exp=%b", k, tick_div, ediv); end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_subtap();
        test_nco_no_drift();
        test_divider();
        test_cfg();
        test_clr_en();
        test_max_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
